// File: rtl/adau1761_cfg_seq.sv
// ADAU1761 register-configuration sequencer: walks a synchronous config ROM and
// issues each entry as a 4-byte I2C write through a byte-level master, retrying on NACK.
module adau1761_cfg_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'h70,
  parameter logic [19:0] STARTUP_CYCLES = 20'd480000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [15:0] GAP_CYCLES     = 16'd4800
) (
  input  logic        clk_48,
  input  logic        reset_n,
  input  logic        start,
  output logic [5:0]  rom_addr,
  input  logic [24:0] rom_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_byte,
  output logic        cmd_start,
  output logic        cmd_stop,
  input  logic        rsp_valid,
  input  logic        rsp_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  err_idx
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_RSP,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [19:0]        pwr_cnt_q, pwr_cnt_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [24:0]        entry_q, entry_d;
  logic [5:0]         rom_addr_q, rom_addr_d;
  logic [5:0]         err_idx_q, err_idx_d;

  logic pwr_last;
  logic gap_last;
  logic entry_last;

  // A zero-length wait parameter behaves as a single cycle instead of wrapping.
  assign pwr_last   = (STARTUP_CYCLES == 20'd0) || (pwr_cnt_q == STARTUP_CYCLES - 20'd1);
  assign gap_last   = (GAP_CYCLES == 16'd0) || (gap_cnt_q == GAP_CYCLES - 16'd1);
  assign entry_last = entry_q[24];

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    retry_d    = retry_q;
    byte_idx_d = byte_idx_q;
    entry_d    = entry_q;
    rom_addr_d = rom_addr_q;
    err_idx_d  = err_idx_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_PWR_WAIT;
          pwr_cnt_d  = 20'd0;
          rom_addr_d = 6'd0;
          retry_d    = '0;
        end
      end

      ST_PWR_WAIT: begin
        if (pwr_last) begin
          state_d   = ST_FETCH;
          pwr_cnt_d = 20'd0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 20'd1;
        end
      end

      ST_FETCH: begin
        entry_d    = rom_data;
        byte_idx_d = 2'd0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (cmd_ready) begin
          state_d = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          if (rsp_ack) begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_d = byte_idx_q + 2'd1;
              state_d    = ST_SEND;
            end else if (entry_last) begin
              state_d = ST_DONE;
            end else if (rom_addr_q == 6'd63) begin
              // Table ran off the end without a terminator.
              err_idx_d = 6'd63;
              state_d   = ST_ERROR;
            end else begin
              rom_addr_d = rom_addr_q + 6'd1;
              retry_d    = '0;
              state_d    = ST_FETCH;
            end
          end else if (retry_q < RETRY_LIMIT) begin
            retry_d   = retry_q + RETRY_W'(1);
            gap_cnt_d = 16'd0;
            state_d   = ST_GAP;
          end else begin
            err_idx_d = rom_addr_q;
            state_d   = ST_ERROR;
          end
        end
      end

      ST_GAP: begin
        if (gap_last) begin
          gap_cnt_d  = 16'd0;
          byte_idx_d = 2'd0;
          state_d    = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pwr_cnt_q  <= 20'd0;
      gap_cnt_q  <= 16'd0;
      retry_q    <= '0;
      byte_idx_q <= 2'd0;
      entry_q    <= 25'd0;
      rom_addr_q <= 6'd0;
      err_idx_q  <= 6'd0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      retry_q    <= retry_d;
      byte_idx_q <= byte_idx_d;
      entry_q    <= entry_d;
      rom_addr_q <= rom_addr_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // The ROM registers its address, so present the next index one cycle early;
  // FETCH then latches data for the index the sequencer has just moved to.
  assign rom_addr = rom_addr_d;

  always_comb begin
    cmd_byte = 8'h00;
    if (state_q == ST_SEND) begin
      unique case (byte_idx_q)
        2'd0:    cmd_byte = DEV_ADDR;
        2'd1:    cmd_byte = entry_q[23:16];
        2'd2:    cmd_byte = entry_q[15:8];
        default: cmd_byte = entry_q[7:0];
      endcase
    end
  end

  assign cmd_valid = (state_q == ST_SEND);
  assign cmd_start = (state_q == ST_SEND) && (byte_idx_q == 2'd0);
  assign cmd_stop  = (state_q == ST_SEND) && (byte_idx_q == 2'd3);
  assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_adau1761_cfg_seq.sv
// Self-checking bench for adau1761_cfg_seq: a byte-master responder with random
// stalls/latency against a transaction-level model of the expected I2C traffic.
module tb_adau1761_cfg_seq;

  localparam logic [7:0]  DEV     = 8'h70;
  localparam logic [19:0] STARTUP = 20'd40;
  localparam int          MAXR    = 3;
  localparam logic [15:0] GAP     = 16'd25;
  localparam int          TIMEOUT = 20000;

  logic        clk_48;
  logic        reset_n;
  logic        start;
  logic [5:0]  rom_addr;
  logic [24:0] rom_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_byte;
  logic        cmd_start;
  logic        cmd_stop;
  logic        rsp_valid;
  logic        rsp_ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  err_idx;

  adau1761_cfg_seq #(
    .DEV_ADDR       (DEV),
    .STARTUP_CYCLES (STARTUP),
    .MAX_RETRY      (MAXR),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk_48    (clk_48),
    .reset_n   (reset_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_byte  (cmd_byte),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .rsp_valid (rsp_valid),
    .rsp_ack   (rsp_ack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_idx   (err_idx)
  );

  initial begin
    clk_48 = 1'b0;
    forever #5 clk_48 = ~clk_48;
  end

  // Synchronous config ROM: data is valid the cycle after the address.
  logic [24:0] rom_mem [64];
  always @(posedge clk_48) rom_data <= rom_mem[rom_addr];

  int checks = 0;
  int errors = 0;

  // Fault plan and model results.
  int          nack_cnt [64];
  int          nack_pos [64];
  logic [9:0]  exp_bytes [$];
  bit          exp_acks  [$];
  int          exp_idle  [$];
  bit          exp_done;
  bit          exp_err;
  int          exp_err_idx;

  // Responder state and observations.
  logic [9:0]  mon_q [$];
  int          idle_q [$];
  bit          drv_acks [$];
  bit          pending, measuring, holding, cur_ack;
  int          rsp_dly, idle_cnt, stall_left;
  int          stall_cycles, stab_viol, valid_cycles, valid_in_wait;
  logic [9:0]  held;
  bit          rand_stall, stray_en, force_stall_en;
  int          force_stall_at, force_stall_len;

  function automatic logic [7:0] byte_of(input logic [24:0] ent, input int b);
    case (b)
      0:       return DEV;
      1:       return ent[23:16];
      2:       return ent[15:8];
      default: return ent[7:0];
    endcase
  endfunction

  // Transaction-level model: per entry, attempts of 4 bytes until an attempt is
  // fully ACKed or the retry budget is exhausted; also predicts idle cycles between
  // a response and the next command (0 within an entry, 1 for the refetch, GAP on retry).
  task automatic build_model();
    exp_bytes.delete(); exp_acks.delete(); exp_idle.delete();
    exp_done = 0; exp_err = 0; exp_err_idx = 0;
    for (int e = 0; e < 64; e++) begin
      int attempts = 0;
      bit ok = 0;
      while (!ok) begin
        bit nacked = 0;
        for (int b = 0; b < 4; b++) begin
          exp_bytes.push_back({(b == 0), (b == 3), byte_of(rom_mem[e], b)});
          if (attempts < nack_cnt[e] && b == nack_pos[e]) begin
            exp_acks.push_back(1'b0);
            nacked = 1;
            break;
          end
          exp_acks.push_back(1'b1);
          if (b < 3) exp_idle.push_back(0);
        end
        if (nacked) begin
          attempts++;
          if (attempts > MAXR) begin
            exp_err = 1; exp_err_idx = e;
            return;
          end
          exp_idle.push_back(int'(GAP));
        end else begin
          ok = 1;
        end
      end
      if (rom_mem[e][24]) begin
        exp_done = 1;
        return;
      end
      if (e == 63) begin
        exp_err = 1; exp_err_idx = 63;
        return;
      end
      exp_idle.push_back(1);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) begin
      nack_cnt[i] = 0;
      nack_pos[i] = 0;
    end
    rand_stall = 0; stray_en = 0; force_stall_en = 0;
    force_stall_at = 0; force_stall_len = 0;
  endtask

  // Byte-master responder; acts on falling edges so DUT outputs are settled.
  initial begin : responder
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_ack = 1'b0;
    pending = 0; measuring = 0; holding = 0; cur_ack = 1;
    rsp_dly = 0; idle_cnt = 0; stall_left = 0;
    stall_cycles = 0; stab_viol = 0; valid_cycles = 0; valid_in_wait = 0;
    forever begin
      @(negedge clk_48);
      rsp_valid = 1'b0;
      if (!reset_n) begin
        pending = 0; measuring = 0; holding = 0; cmd_ready = 1'b0;
      end else begin
        if (measuring) begin
          if (cmd_valid) begin
            idle_q.push_back(idle_cnt);
            measuring = 0;
          end else begin
            idle_cnt++;
          end
        end
        if (cmd_valid) begin
          valid_cycles++;
          if (pending) valid_in_wait++;
          if (holding && {cmd_start, cmd_stop, cmd_byte} !== held) stab_viol++;
          if (!holding) begin
            held = {cmd_start, cmd_stop, cmd_byte};
            holding = 1;
            if (force_stall_en && mon_q.size() == force_stall_at) stall_left = force_stall_len;
            else stall_left = rand_stall ? int'($urandom_range(0, 2)) : 0;
          end
          if (stall_left == 0) begin
            cmd_ready = 1'b1;
            mon_q.push_back({cmd_start, cmd_stop, cmd_byte});
            holding = 0;
            cur_ack = (drv_acks.size() > 0) ? drv_acks.pop_front() : 1'b1;
            pending = 1;
            rsp_dly = rand_stall ? int'($urandom_range(0, 3)) : 0;
          end else begin
            cmd_ready = 1'b0;
            stall_left--;
            stall_cycles++;
          end
        end else begin
          cmd_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
          if (pending) begin
            if (rsp_dly == 0) begin
              rsp_valid = 1'b1;
              rsp_ack   = cur_ack;
              pending   = 0;
              measuring = 1;
              idle_cnt  = 0;
            end else begin
              rsp_dly--;
            end
          end else if (stray_en && $urandom_range(0, 7) == 0) begin
            rsp_valid = 1'b1;
            rsp_ack   = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  end

  // Runs one full sequence from a start pulse and scores it against the model.
  task automatic run_sequence(input string name, input bit glitch_start);
    int low, cyc, vc_end, n;
    build_model();
    @(posedge clk_48); #1;
    mon_q.delete(); idle_q.delete();
    drv_acks = exp_acks;
    pending = 0; measuring = 0; holding = 0;
    stab_viol = 0; stall_cycles = 0; valid_in_wait = 0;
    @(negedge clk_48); start = 1'b1;
    @(negedge clk_48); start = 1'b0;
    low = 0;
    while (!cmd_valid && low < 1000) begin
      low++;
      @(negedge clk_48);
    end
    checks++;
    if (low !== int'(STARTUP) + 1) begin
      errors++; $display("FAIL %s startup_wait: got %0d cycles want %0d", name, low, int'(STARTUP) + 1);
    end
    if (glitch_start) begin
      start = 1'b1;
      @(negedge clk_48); start = 1'b0;
    end
    cyc = 0;
    while (!(done || error) && cyc < TIMEOUT) begin
      cyc++;
      @(negedge clk_48);
    end
    checks++;
    if (cyc >= TIMEOUT) begin
      errors++; $display("FAIL %s timeout: got no done/error within %0d cycles", name, TIMEOUT);
    end
    checks++;
    if (done !== exp_done) begin
      errors++; $display("FAIL %s done: got %b want %b", name, done, exp_done);
    end
    checks++;
    if (error !== exp_err) begin
      errors++; $display("FAIL %s error: got %b want %b", name, error, exp_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_end: got %b want 0", name, busy);
    end
    if (exp_err) begin
      checks++;
      if (err_idx !== 6'(exp_err_idx)) begin
        errors++; $display("FAIL %s err_idx: got %0d want %0d", name, err_idx, exp_err_idx);
      end
    end
    vc_end = valid_cycles;
    repeat (40) @(negedge clk_48);
    checks++;
    if (valid_cycles !== vc_end || done !== exp_done || error !== exp_err) begin
      errors++; $display("FAIL %s terminal_hold: got %0d extra valid cycles done=%b error=%b want 0 %b %b",
                         name, valid_cycles - vc_end, done, error, exp_done, exp_err);
    end
    checks++;
    if (mon_q.size() !== exp_bytes.size()) begin
      errors++; $display("FAIL %s byte_count: got %0d want %0d", name, mon_q.size(), exp_bytes.size());
    end
    n = (mon_q.size() < exp_bytes.size()) ? mon_q.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mon_q[i] !== exp_bytes[i]) begin
        errors++; $display("FAIL %s byte[%0d] {start,stop,byte}: got %b_%b_%h want %b_%b_%h", name, i,
                           mon_q[i][9], mon_q[i][8], mon_q[i][7:0], exp_bytes[i][9], exp_bytes[i][8], exp_bytes[i][7:0]);
      end
    end
    checks++;
    if (idle_q.size() !== exp_idle.size()) begin
      errors++; $display("FAIL %s idle_count: got %0d want %0d", name, idle_q.size(), exp_idle.size());
    end
    n = (idle_q.size() < exp_idle.size()) ? idle_q.size() : exp_idle.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (idle_q[i] !== exp_idle[i]) begin
        errors++; $display("FAIL %s idle[%0d]: got %0d cycles want %0d", name, i, idle_q[i], exp_idle[i]);
      end
    end
    checks++;
    if (valid_in_wait !== 0 || stab_viol !== 0) begin
      errors++; $display("FAIL %s handshake: got %0d valid-while-outstanding, %0d unstable cycles want 0 0",
                         name, valid_in_wait, stab_viol);
    end
  endtask

  task automatic load_v1_table();
    for (int i = 0; i < 64; i++) rom_mem[i] = {1'b0, 24'($urandom)};
    rom_mem[0] = {1'b0, 16'h4000, 8'h01};
    rom_mem[1] = {1'b0, 16'h4015, 8'h01};
    rom_mem[2] = {1'b1, 16'h40F9, 8'h7F};
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0;
    clear_plan();
    load_v1_table();
    repeat (3) @(posedge clk_48);
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (cmd_start !== 1'b0) begin errors++; $display("FAIL reset cmd_start: got %b want 0", cmd_start); end
    checks++; if (cmd_stop  !== 1'b0) begin errors++; $display("FAIL reset cmd_stop: got %b want 0", cmd_stop); end
    checks++; if (cmd_byte  !== 8'h00) begin errors++; $display("FAIL reset cmd_byte: got %h want 00", cmd_byte); end
    checks++; if (busy      !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done      !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (error     !== 1'b0) begin errors++; $display("FAIL reset error: got %b want 0", error); end
    checks++; if (rom_addr  !== 6'd0) begin errors++; $display("FAIL reset rom_addr: got %0d want 0", rom_addr); end
    checks++; if (err_idx   !== 6'd0) begin errors++; $display("FAIL reset err_idx: got %0d want 0", err_idx); end
    reset_n = 1'b1;
    repeat (10) @(negedge clk_48);
    checks++;
    if (busy !== 1'b0 || valid_cycles !== 0) begin
      errors++; $display("FAIL reset no_autostart: got busy=%b valid_cycles=%0d want 0 0", busy, valid_cycles);
    end
  endtask

  task automatic test_basic();
    clear_plan();
    load_v1_table();
    run_sequence("basic", 1'b0);
  endtask

  task automatic test_backpressure();
    clear_plan();
    load_v1_table();
    force_stall_en = 1; force_stall_at = 2; force_stall_len = 10;
    run_sequence("backpressure", 1'b0);
    checks++;
    if (stall_cycles !== 10) begin
      errors++; $display("FAIL backpressure stall_cycles: got %0d want 10", stall_cycles);
    end
  endtask

  task automatic test_retry();
    clear_plan();
    load_v1_table();
    nack_cnt[1] = 1; nack_pos[1] = 1;
    run_sequence("retry", 1'b0);
  endtask

  task automatic test_error();
    clear_plan();
    load_v1_table();
    nack_cnt[2] = 4; nack_pos[2] = 3;
    run_sequence("error", 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [25:0] outs;
    clear_plan();
    load_v1_table();
    build_model();
    @(posedge clk_48); #1;
    mon_q.delete(); idle_q.delete(); drv_acks = exp_acks;
    @(negedge clk_48); start = 1'b1;
    @(negedge clk_48); start = 1'b0;
    cyc = 0;
    @(posedge clk_48); #1;
    while (!(pending && mon_q.size() == 5) && cyc < 2000) begin
      cyc++;
      @(posedge clk_48); #1;
    end
    checks++;
    if (cyc >= 2000) begin
      errors++; $display("FAIL reset_mid reach_entry1: got no outstanding byte of entry 1 within 2000 cycles");
    end
    reset_n = 1'b0;
    #1;
    outs = {cmd_valid, cmd_start, cmd_stop, busy, done, error, cmd_byte, rom_addr, err_idx};
    checks++;
    if (outs !== 26'd0) begin
      errors++; $display("FAIL reset_mid outputs: got %h want 0000000", outs);
    end
    repeat (3) @(posedge clk_48);
    #1 reset_n = 1'b1;
    cyc = valid_cycles;
    repeat (30) @(negedge clk_48);
    checks++;
    if (busy !== 1'b0 || valid_cycles !== cyc) begin
      errors++; $display("FAIL reset_mid no_restart: got busy=%b extra_valid=%0d want 0 0", busy, valid_cycles - cyc);
    end
    run_sequence("reset_mid_rerun", 1'b0);
  endtask

  task automatic test_start_ignored();
    clear_plan();
    load_v1_table();
    stray_en = 1;
    run_sequence("start_in_send", 1'b1);
    run_sequence("start_in_done", 1'b0);
  endtask

  task automatic test_addr_limit();
    clear_plan();
    for (int i = 0; i < 64; i++) rom_mem[i] = {1'b0, 24'($urandom)};
    rand_stall = 1;
    run_sequence("addr_limit", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n;
      clear_plan();
      rand_stall = 1; stray_en = 1;
      n = int'($urandom_range(1, 8));
      for (int e = 0; e < 64; e++) begin
        rom_mem[e] = {(e == n - 1), 24'($urandom)};
        if ($urandom_range(0, 9) > 6) begin
          nack_cnt[e] = int'($urandom_range(1, 4));
          nack_pos[e] = int'($urandom_range(0, 3));
        end
      end
      run_sequence($sformatf("random%0d", it), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_retry();
    test_error();
    test_reset_mid();
    test_start_ignored();
    test_addr_limit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adau1761_cfg_seq.md
ADAU1761_CFG_SEQ -- requirements
Module: adau1761_cfg_seq

Interface
- REQ-001 Parameter DEV_ADDR, default 8'h70, shall be the I2C write-address byte (7-bit 0x38, R/W=0).
- REQ-002 Parameter STARTUP_CYCLES, default 20'd480000, shall be the power-up wait in clk_48 cycles (10 ms).
- REQ-003 Parameter MAX_RETRY, default 3, shall be the number of retries per entry after the first attempt.
- REQ-004 Parameter GAP_CYCLES, default 16'd4800, shall be the idle gap before each retry (100 us).
- REQ-005 Port clk_48, input, 1: sole clock; all logic rising-edge.
- REQ-006 Port reset_n, input, 1: reset; one clock; reset is asynchronous and active-low.
- REQ-007 Port start, input, 1: one-cycle pulse that launches the configuration sequence.
- REQ-008 Port rom_addr, output, 6: config-table index.
- REQ-009 Port rom_data, input, 25: {last, reg_addr[15:0], reg_data[7:0]}; synchronous ROM, valid 1 cycle after rom_addr.
- REQ-010 Port cmd_valid, output, 1; cmd_ready, input, 1: byte-command handshake to the I2C byte master.
- REQ-011 Port cmd_byte, output, 8; cmd_start, output, 1; cmd_stop, output, 1: byte to send, START before it, STOP after it.
- REQ-012 Port rsp_valid, input, 1; rsp_ack, input, 1: one-cycle per-byte result (1 = ACK); on NACK the master issues STOP itself.
- REQ-013 Port busy, output, 1; done, output, 1; error, output, 1: status.
- REQ-014 Port err_idx, output, 6: table index of the failing entry.

Function
- REQ-015 States: IDLE, PWR_WAIT, FETCH, SEND, WAIT_RSP, GAP, DONE, ERROR.
- REQ-016 IDLE/DONE/ERROR + start -> PWR_WAIT; clear done, error, rom_addr, retry count; start ignored in every other state.
- REQ-017 PWR_WAIT: count STARTUP_CYCLES cycles, then FETCH; busy=1 in all states except IDLE/DONE/ERROR.
- REQ-018 FETCH: one cycle, latch rom_data into entry register, byte index=0, -> SEND.
- REQ-019 Each entry = 4 bytes in order: DEV_ADDR, reg_addr[15:8], reg_addr[7:0], reg_data; cmd_start=1 on byte 0 only, cmd_stop=1 on byte 3 only.
- REQ-020 SEND: assert cmd_valid with stable cmd_byte/cmd_start/cmd_stop until the cycle cmd_ready=1; transfer on valid&ready; then WAIT_RSP; at most one byte outstanding.
- REQ-021 cmd_valid shall be 0 outside SEND; deasserts the cycle after transfer.
- REQ-022 WAIT_RSP + rsp_valid&rsp_ack: byte<3 -> byte+1, SEND; byte=3 and last=0 -> rom_addr+1, retry count=0, FETCH; byte=3 and last=1 -> DONE.
- REQ-023 WAIT_RSP + rsp_valid&!rsp_ack: retry count<MAX_RETRY -> count+1, GAP; else err_idx=rom_addr, ERROR.
- REQ-024 GAP: wait GAP_CYCLES cycles, then byte index=0, SEND (same entry, no refetch).
- REQ-025 DONE: done=1 held; ERROR: error=1 held; both until next start or reset.
- REQ-026 rsp_valid outside WAIT_RSP shall be ignored; cmd_ready outside SEND shall be ignored.
- REQ-027 rom_addr at 63 with last=0 after its ACK shall go to ERROR with err_idx=63 (no wrap).
- REQ-028 Counters saturate-free: sized to their parameter; no arithmetic overflow permitted.

Reset
- REQ-029 reset_n low shall immediately force IDLE; cmd_valid, cmd_start, cmd_stop, busy, done, error=0; cmd_byte=8'h00; rom_addr, err_idx=0; all counters 0.
- REQ-030 Reset mid-transfer shall abandon the entry; no automatic restart after release; start required.

Verification
- V1 start, 3-entry table {0x4000,0x01},{0x4015,0x01},{0x40F9,0x7F,last}, all ACK -> bytes 70 40 00 01 / 70 40 15 01 / 70 40 F9 7F, start only on 0x70, stop only on data byte, done=1, busy=0.
- V2 cmd_ready held low 10 cycles on byte 2 -> cmd_valid and cmd_byte stable all 10 cycles, single transfer.
- V3 NACK on entry 1 byte 1 once -> GAP_CYCLES idle, entry 1 resent from 0x70, sequence completes with done=1.
- V4 NACK on entry 2 four times (MAX_RETRY=3) -> error=1, err_idx=2, done=0, no further cmd_valid.
- V5 reset_n low during WAIT_RSP of entry 1 -> all outputs at reset values next edge; start after release -> PWR_WAIT then entry 0.
- V6 start pulsed during SEND -> ignored, sequence unchanged; start in DONE -> full rerun.
